vga_fb_ctrl: RTL



---
 rtl/vga_fb_ctrl_if.sv | 21 ++
 rtl/vga_fb_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_fb_ctrl_if.sv
// APB-lite bus bundle for the VGA frame-buffer controller configuration port.
interface vga_fb_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/vga_fb_ctrl.sv
// VGA frame-buffer descriptor/scheduling unit: APB registers, vsync-aligned ping-pong swap, frame IRQ.
// Optional FRAME_CNT register at 0x20 is built when VGA_FB_FRAME_CNT_EN is defined.
module vga_fb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter bit          VSYNC_POL  = 1'b0
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  vga_fb_ctrl_if.slave          apb,
  input  logic                  vsync_i,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic [ADDR_WIDTH-1:0] top_addr_o,
  output logic                  self_test_o,
  output logic                  vga_en_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PEND} state_t;

  state_t state, state_nxt;

  logic                  ctrl_en, ctrl_ie;
  logic                  active_buf, swap_pend, frame_irq;
  logic [ADDR_WIDTH-1:0] fb0, fb1, fb_sel;
  logic [63:0]           fb0_ext, fb1_ext;
  logic [31:0]           fb_size;
  logic [2:0]            vs_sync;
  logic                  frame_evt;
  logic                  access, wr;
  logic [3:0]            widx;
  logic                  swap_req;
  logic                  load_out, toggle_buf, en_nxt;
  logic                  unused_ok;

  assign access   = apb.psel & apb.penable;
  assign wr       = access & apb.pwrite;
  assign widx     = apb.paddr[5:2];
  assign swap_req = wr && (widx == 4'd7) && apb.pwdata[0];
  assign unused_ok = ^apb.paddr[1:0];

  assign fb0_ext = 64'(fb0);
  assign fb1_ext = 64'(fb1);
  assign fb_sel  = active_buf ? fb1 : fb0;

  // vs_sync[1] is the synchronized level; vs_sync[2] is its previous value.
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) vs_sync <= '0;
    else           vs_sync <= {vs_sync[1:0], vsync_i};
  end

  assign frame_evt = ~(vs_sync[1] ^ VSYNC_POL) & (vs_sync[2] ^ VSYNC_POL);

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) state <= IDLE;
    else           state <= state_nxt;
  end

  // A swap re-enters LOAD so the reload path is shared with enable.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_en)   state_nxt = LOAD;
      LOAD:                   state_nxt = RUN;
      RUN:     if (swap_req)  state_nxt = PEND;
      PEND:    if (frame_evt) state_nxt = LOAD;
      default:                state_nxt = IDLE;
    endcase
    if (!ctrl_en) state_nxt = IDLE;
  end

  always_comb begin
    load_out   = (state == LOAD) && (state_nxt == RUN);
    toggle_buf = (state == PEND) && (state_nxt == LOAD);
    en_nxt     = (state_nxt == RUN) || (state_nxt == PEND) || toggle_buf;
  end

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      base_addr_o <= '0;
      top_addr_o  <= '0;
      vga_en_o    <= 1'b0;
      swap_pend   <= 1'b0;
      active_buf  <= 1'b0;
    end else begin
      vga_en_o  <= en_nxt;
      swap_pend <= (state_nxt == PEND);
      if (toggle_buf) active_buf <= ~active_buf;
      if (load_out) begin
        base_addr_o <= fb_sel;
        top_addr_o  <= fb_sel + ADDR_WIDTH'(fb_size);
      end
    end
  end

  // HI-word writes beyond ADDR_WIDTH fall away in the truncating cast.
  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      ctrl_en     <= 1'b0;
      self_test_o <= 1'b0;
      ctrl_ie     <= 1'b0;
      fb0         <= '0;
      fb1         <= '0;
      fb_size     <= '0;
      frame_irq   <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (wr) begin
        case (widx)
          4'd0: begin
            ctrl_en     <= apb.pwdata[0];
            self_test_o <= apb.pwdata[1];
            ctrl_ie     <= apb.pwdata[2];
          end
          4'd2:    fb0     <= ADDR_WIDTH'({fb0_ext[63:32], apb.pwdata});
          4'd3:    fb0     <= ADDR_WIDTH'({apb.pwdata, fb0_ext[31:0]});
          4'd4:    fb1     <= ADDR_WIDTH'({fb1_ext[63:32], apb.pwdata});
          4'd5:    fb1     <= ADDR_WIDTH'({apb.pwdata, fb1_ext[31:0]});
          4'd6:    fb_size <= apb.pwdata;
          default: ;
        endcase
      end
      if (frame_evt && vga_en_o)                      frame_irq <= 1'b1;
      else if (wr && (widx == 4'd1) && apb.pwdata[2]) frame_irq <= 1'b0;
      irq_o <= frame_irq & ctrl_ie;
    end
  end

`ifdef VGA_FB_FRAME_CNT_EN
  logic [31:0] frame_cnt;

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a)                     frame_cnt <= '0;
    else if (wr && (widx == 4'd8))     frame_cnt <= '0;
    else if (frame_evt && vga_en_o)    frame_cnt <= frame_cnt + 32'd1;
  end
`else
  logic [31:0] frame_cnt;
  assign frame_cnt = '0;
`endif

  always_comb begin
    apb.prdata = '0;
    if (access) begin
      case (widx)
        4'd0:    apb.prdata = {29'd0, ctrl_ie, self_test_o, ctrl_en};
        4'd1:    apb.prdata = {29'd0, frame_irq, swap_pend, active_buf};
        4'd2:    apb.prdata = fb0_ext[31:0];
        4'd3:    apb.prdata = fb0_ext[63:32];
        4'd4:    apb.prdata = fb1_ext[31:0];
        4'd5:    apb.prdata = fb1_ext[63:32];
        4'd6:    apb.prdata = fb_size;
        4'd8:    apb.prdata = frame_cnt;
        default: apb.prdata = '0;
      endcase
    end
  end

  assign apb.pslverr = access && (widx > 4'd8);
  assign apb.pready  = 1'b1;

endmodule
